// File: rtl/hex_display_driver_pkg.sv
// Shared constants and types for the hex display driver: segment encodings and FSM states.
package hex_display_driver_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment patterns, index = nibble value, bit0=a .. bit6=g
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/hex_display_driver_hex_to_seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg
  import hex_display_driver_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = seg_decode(nib);

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit hex display driver: digit-serial decode through one shared decoder,
// optional leading-zero suppression, and an output-side blink mask.
module hex_display_driver
  import hex_display_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [NUM_DIGITS*4-1:0] load_data,
  input  logic                    lz_en,
  input  logic                    blink_en,
  output logic                    busy,
  output logic [NUM_DIGITS*7-1:0] segs
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BLINK_DIV);

  state_e                         state_q, state_d;
  logic                           accept;
  logic [NUM_DIGITS-1:0][3:0]     data_q;
  logic [IDX_W-1:0]               idx_q;
  logic                           lz_q;
  logic                           seen_q;
  logic [NUM_DIGITS-1:0][6:0]     seg_q;
  logic [3:0]                     nib;
  logic [6:0]                     dec;
  logic [6:0]                     wr_seg;
  logic                           suppress;
  logic                           last;
  logic [CNT_W-1:0]               cnt_q;
  logic                           off_q;

  assign nib      = data_q[idx_q];
  assign last     = (idx_q == '0);
  // Digit 0 is never suppressed so an all-zero value still shows "0"
  assign suppress = lz_q && !seen_q && (nib == 4'h0) && !last;
  assign wr_seg   = suppress ? SEG_BLANK : dec;

  hex_to_seg u_dec (
    .nib (nib),
    .seg (dec)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          accept  = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == UPDATE);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      lz_q    <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= load_data;
        lz_q   <= lz_en;
        idx_q  <= IDX_W'(NUM_DIGITS - 1);
        seen_q <= 1'b0;
      end else if (busy) begin
        idx_q <= idx_q - 1'b1;
        if (!suppress && nib != 4'h0) seen_q <= 1'b1;
      end
    end
  end

  // Per-digit segment registers; only the digit under idx is rewritten each UPDATE cycle
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn)                            seg_q[d] <= SEG_BLANK;
      else if (busy && idx_q == IDX_W'(d))    seg_q[d] <= wr_seg;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      off_q <= 1'b0;
    end else if (!blink_en) begin
      cnt_q <= '0;
      off_q <= 1'b0;
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_q <= '0;
      off_q <= ~off_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Blink masks only the output; stored digits and any UPDATE are unaffected
  assign segs = off_q ? '1 : seg_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Randomized and directed bench for hex_display_driver against a digit-rule reference model.
module tb_hex_display_driver;

  localparam int ND = 6;
  localparam int BD = 4;
  localparam logic [ND*7-1:0] ALL_BLANK = '1;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            load_valid = 1'b0;
  logic            load_ready;
  logic [ND*4-1:0] load_data = '0;
  logic            lz_en = 1'b0;
  logic            blink_en = 1'b0;
  logic            busy;
  logic [ND*7-1:0] segs;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [ND*7-1:0] shown;

  hex_display_driver #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .lz_en      (lz_en),
    .blink_en   (blink_en),
    .busy       (busy),
    .segs       (segs)
  );

  always #5 clk = ~clk;

  // Display expected once a value has fully landed: digits above the most
  // significant nonzero nibble are blank when suppression is on, digit 0 never is.
  function automatic logic [ND*7-1:0] model(input logic [ND*4-1:0] v, input bit lz);
    logic [ND*7-1:0] r;
    int msd;
    int n;
    r = '0;
    msd = 0;
    for (int i = 0; i < ND; i++) if (((v >> (4*i)) & 'hF) != 0) msd = i;
    for (int i = 0; i < ND; i++) begin
      n = int'((v >> (4*i)) & 'hF);
      r[7*i +: 7] = (lz && i > msd) ? 7'h7F : lut[n];
    end
    return r;
  endfunction

  // Digits at or above cut come from nw, the rest still hold old
  function automatic logic [ND*7-1:0] mix(input logic [ND*7-1:0] nw, input logic [ND*7-1:0] old, input int cut);
    logic [ND*7-1:0] r;
    for (int i = 0; i < ND; i++) r[7*i +: 7] = (i >= cut) ? nw[7*i +: 7] : old[7*i +: 7];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (load_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("ready_timeout", 64'(load_ready), 64'd1);
  endtask

  task automatic do_load(input logic [ND*4-1:0] v, input bit lz);
    logic [ND*7-1:0] exp;
    wait_ready();
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = v;
    lz_en      = lz;
    @(posedge clk); #1;
    load_valid = 1'b0;
    chk("ready_after_accept", 64'(load_ready), 64'd0);
    exp = model(v, lz);
    for (int k = 1; k <= ND; k++) begin
      @(posedge clk); #1;
      chk("ready_window", 64'(load_ready), 64'(k == ND));
      if (k == 2) chk("partial_segs", 64'(segs), 64'(mix(exp, shown, ND-2)));
    end
    chk("final_segs", 64'(segs), 64'(exp));
    shown = exp;
  endtask

  initial begin
    logic [ND*4-1:0] a, b, v;
    logic [ND*7-1:0] ea, eb;
    shown = ALL_BLANK;

    // reset state
    #12;
    chk("reset_segs", 64'(segs), 64'(ALL_BLANK));
    chk("reset_ready", 64'(load_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk); resetn = 1'b1;

    // directed values
    do_load(24'h0123AF, 1'b0);
    chk("basic_d5", 64'(segs[41:35]), 64'h40);
    chk("basic_d0", 64'(segs[6:0]), 64'h0E);
    do_load(24'h00012A, 1'b1);
    do_load(24'h000000, 1'b1);
    chk("zero_d0", 64'(segs[6:0]), 64'h40);
    do_load(24'h000000, 1'b0);
    do_load(24'h800000, 1'b1);

    // load_valid held through UPDATE is only taken once ready returns
    a = 24'h00C0DE; b = 24'h9876E5;
    ea = model(a, 1'b1); eb = model(b, 1'b0);
    @(negedge clk);
    load_valid = 1'b1; load_data = a; lz_en = 1'b1;
    @(posedge clk); #1;
    load_data = b; lz_en = 1'b0;
    for (int k = 1; k <= ND; k++) begin
      @(posedge clk); #1;
      chk("hs_busy", 64'(busy), 64'(k != ND));
      if (k == 2) chk("hs_partial_a", 64'(segs), 64'(mix(ea, shown, ND-2)));
    end
    chk("hs_final_a", 64'(segs), 64'(ea));
    @(posedge clk); #1;
    load_valid = 1'b0;
    chk("hs_accept_b", 64'(busy), 64'd1);
    for (int k = 1; k <= ND; k++) begin
      @(posedge clk); #1;
      if (k == 3) chk("hs_partial_b", 64'(segs), 64'(mix(eb, ea, ND-3)));
    end
    chk("hs_final_b", 64'(segs), 64'(eb));
    shown = eb;

    // randomized values, with random leading-zero runs
    for (int r = 0; r < 25; r++) begin
      v = ND*4'($urandom) >> (4 * $urandom_range(0, ND-1));
      do_load(v, 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of an update
    wait_ready();
    @(negedge clk);
    load_valid = 1'b1; load_data = 24'hABCDEF; lz_en = 1'b0;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midreset_segs", 64'(segs), 64'(ALL_BLANK));
    chk("midreset_ready", 64'(load_ready), 64'd1);
    chk("midreset_busy", 64'(busy), 64'd0);
    @(negedge clk); resetn = 1'b1;
    shown = ALL_BLANK;
    @(posedge clk); #1;
    chk("postreset_segs", 64'(segs), 64'(ALL_BLANK));

    // blink: four cycles on, four off; dropping enable restores next cycle
    do_load(24'h0123AF, 1'b0);
    @(negedge clk); blink_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      chk("blink_phase", 64'(segs), 64'((((k / BD) % 2) == 1) ? ALL_BLANK : shown));
    end
    @(negedge clk); blink_en = 1'b0;
    @(posedge clk); #1;
    chk("blink_restore", 64'(segs), 64'(shown));
    repeat (5) @(posedge clk);
    #1 chk("blink_held_off", 64'(segs), 64'(shown));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
